// File: rtl/iter_shift_ctrl_pkg.sv
// iter_shift_ctrl_pkg: shared op codes and FSM state encoding for the serial shifter
package iter_shift_ctrl_pkg;
  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/shift1_stage.sv
// shift1_stage: one-bit rotate/shift stage reused every cycle by the serial shifter
module shift1_stage
  import iter_shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out
);
  assign Out = (Op == OP_ROL) ? {In[WIDTH-2:0], In[WIDTH-1]} :
               (Op == OP_SLL) ? {In[WIDTH-2:0], 1'b0} :
               (Op == OP_ROR) ? {In[0], In[WIDTH-1:1]} :
                                {1'b0, In[WIDTH-1:1]};
endmodule

// File: rtl/iter_shift_ctrl.sv
// iter_shift_ctrl: multi-cycle shifter applying a single-bit stage once per cycle, Cnt times
module iter_shift_ctrl
  import iter_shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out,
  output logic             busy,
  output logic             done
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, stage_out;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;

  shift1_stage #(.WIDTH(WIDTH)) u_stage (
    .In (out_q),
    .Op (op_q),
    .Out(stage_out)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: if (start) begin
        out_d   = In;
        op_d    = Op;
        rem_d   = Cnt;
        state_d = (Cnt != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        out_d   = stage_out;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign Out  = out_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
endmodule

// File: tb/tb_iter_shift_ctrl.sv
// tb_iter_shift_ctrl: directed vector table plus hand-built start-while-busy and reset sequences
module tb_iter_shift_ctrl;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [15:0] in_v = '0;
  logic [3:0]  cnt_v = '0;
  logic [1:0]  op_v = '0;
  logic [15:0] out_w;
  logic        busy, done;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [15:0] in;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  iter_shift_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .In   (in_v),
    .Cnt  (cnt_v),
    .Op   (op_v),
    .Out  (out_w),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                        input logic [15:0] e);
    int n = 0;
    start = 1; in_v = a; cnt_v = c; op_v = o;
    do begin
      tick();
      n++;
      start = 0; op_v = ~o; in_v = ~a;
      if (!done) chk("busy_wait", {31'b0, busy}, 1);
    end while (!done && n < 40);
    chk("latency", n, c + 1);
    chk("out", {16'b0, out_w}, {16'b0, e});
    chk("busy_in_done", {31'b0, busy}, 1);
    tick();
    chk("done_one_cycle", {31'b0, done}, 0);
    chk("idle_after", {31'b0, busy}, 0);
    chk("out_hold", {16'b0, out_w}, {16'b0, e});
  endtask

  initial begin
    vecs[0]  = '{16'h8001, 4'd1,  2'b00, 16'h0003};
    vecs[1]  = '{16'h00FF, 4'd4,  2'b01, 16'h0FF0};
    vecs[2]  = '{16'h0001, 4'd15, 2'b10, 16'h0002};
    vecs[3]  = '{16'h8000, 4'd0,  2'b11, 16'h8000};
    vecs[4]  = '{16'h1234, 4'd4,  2'b00, 16'h2341};
    vecs[5]  = '{16'h1234, 4'd4,  2'b10, 16'h4123};
    vecs[6]  = '{16'hF00F, 4'd8,  2'b11, 16'h00F0};
    vecs[7]  = '{16'hF00F, 4'd8,  2'b01, 16'h0F00};
    vecs[8]  = '{16'hA5A5, 4'd15, 2'b00, 16'hD2D2};
    vecs[9]  = '{16'hFFFF, 4'd15, 2'b01, 16'h8000};
    vecs[10] = '{16'hFFFF, 4'd15, 2'b11, 16'h0001};

    tick(); tick();
    chk("rst_out", {16'b0, out_w}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    rst = 0;
    tick(); tick();
    chk("idle_hold_out", {16'b0, out_w}, 0);
    chk("idle_hold_busy", {31'b0, busy}, 0);

    for (int i = 0; i < 11; i++) run_op(vecs[i].in, vecs[i].cnt, vecs[i].op, vecs[i].exp);

    start = 1; in_v = 16'hF000; cnt_v = 4'd3; op_v = 2'b11;
    tick();
    start = 0;
    tick();
    start = 1; in_v = 16'h1234; cnt_v = 4'd5; op_v = 2'b00;
    tick();
    start = 0;
    chk("busy_start_no_done", {31'b0, done}, 0);
    tick();
    chk("busy_start_done", {31'b0, done}, 1);
    chk("busy_start_out", {16'b0, out_w}, 32'h1E00);
    start = 1; in_v = 16'hFFFF; cnt_v = 4'd0; op_v = 2'b00;
    tick();
    start = 0;
    chk("done_start_ignored_busy", {31'b0, busy}, 0);
    chk("done_start_ignored_out", {16'b0, out_w}, 32'h1E00);

    start = 1; in_v = 16'h00FF; cnt_v = 4'd8; op_v = 2'b01;
    tick();
    start = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_out", {16'b0, out_w}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) chk("midrst_no_done", {31'b0, done}, 0);
    end
    chk("midrst_still_idle", {31'b0, busy}, 0);
    run_op(16'h0001, 4'd2, 2'b01, 16'h0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
